// File: rtl/dmem_mmio_responder_if.sv
// Core-to-data-memory bus: store strobe, byte address, right-aligned store data, access size, load data.
// Loads are combinational and stores commit on the next clock edge; there is no handshake.
interface dmem_mmio_responder_if;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_type;
  logic [31:0] rdata;

  modport master (
    output mem_w,
    output addr,
    output wdata,
    output dm_type,
    input  rdata
  );

  modport slave (
    input  mem_w,
    input  addr,
    input  wdata,
    input  dm_type,
    output rdata
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data RAM with byte/half store lanes and extending loads; DMEM_MMIO_EN adds the LED/CYCLE/CMP/STATUS page at 0xFFFF0000.
// rdata is combinational (zero latency); stores commit on the rising clk edge; never stalls the core.
module dmem_mmio_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_mmio_responder_if.slave bus,
  output logic [15:0]          led,
  output logic                 irq
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic          is_half;
  logic          is_byte;
  logic          is_word;
  logic          sgn;
  logic [3:0]    lane_be;
  logic [31:0]   lane_dat;
  logic [31:0]   ram_word;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;
  logic [31:0]   ram_rdata;
  logic          ram_we;
  logic          ram_commit;
  logic          unused_addr_hi;

  // Upper address bits above the RAM index simply alias.
  assign unused_addr_hi = ^bus.addr[31:AW+2];

  assign widx    = bus.addr[AW+1:2];
  assign is_half = (bus.dm_type == 3'b001) || (bus.dm_type == 3'b010);
  assign is_byte = (bus.dm_type == 3'b011) || (bus.dm_type == 3'b100);
  assign is_word = !is_half && !is_byte;
  assign sgn     = (bus.dm_type == 3'b001) || (bus.dm_type == 3'b011);

  always_comb begin
    lane_be  = 4'b1111;
    lane_dat = bus.wdata;
    if (is_half) begin
      lane_be  = bus.addr[1] ? 4'b1100 : 4'b0011;
      lane_dat = {2{bus.wdata[15:0]}};
    end else if (is_byte) begin
      lane_be  = 4'b0001 << bus.addr[1:0];
      lane_dat = {4{bus.wdata[7:0]}};
    end
  end

  assign ram_word = mem[widx];
  assign half_sel = bus.addr[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    case (bus.addr[1:0])
      2'd0:    byte_sel = ram_word[7:0];
      2'd1:    byte_sel = ram_word[15:8];
      2'd2:    byte_sel = ram_word[23:16];
      default: byte_sel = ram_word[31:24];
    endcase
  end

  always_comb begin
    if (is_half) begin
      ram_rdata = {{16{sgn & half_sel[15]}}, half_sel};
    end else if (is_byte) begin
      ram_rdata = {{24{sgn & byte_sel[7]}}, byte_sel};
    end else begin
      ram_rdata = ram_word;
    end
  end

  // A store presented while reset is high is dropped; RAM contents themselves are never cleared.
  assign ram_commit = ram_we && !reset;

  always_ff @(posedge clk) begin
    if (ram_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) begin
          mem[widx][8*i +: 8] <= lane_dat[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_MMIO_EN
  localparam logic [15:0] OFS_LED  = 16'h0000;
  localparam logic [15:0] OFS_CYC  = 16'h0004;
  localparam logic [15:0] OFS_CMP  = 16'h0008;
  localparam logic [15:0] OFS_STAT = 16'h000C;

  logic [15:0] led_q;
  logic [31:0] cycle_q;
  logic [31:0] cmp_q;
  logic        irq_pend;
  logic        err_q;
  logic        mmio_sel;
  logic        misalign;
  logic        mmio_we;
  logic        stat_we;
  logic [31:0] mmio_rdata;

  assign mmio_sel = (bus.addr[31:16] == 16'hFFFF);
  assign misalign = (is_half && bus.addr[0]) || (is_word && (bus.addr[1:0] != 2'b00));
  assign ram_we   = bus.mem_w && !mmio_sel && !misalign;
  assign mmio_we  = bus.mem_w && mmio_sel && is_word;
  assign stat_we  = mmio_we && (bus.addr[15:0] == OFS_STAT);

  always_comb begin
    case (bus.addr[15:0])
      OFS_LED:  mmio_rdata = {16'h0, led_q};
      OFS_CYC:  mmio_rdata = cycle_q;
      OFS_CMP:  mmio_rdata = cmp_q;
      OFS_STAT: mmio_rdata = {30'h0, err_q, irq_pend};
      default:  mmio_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q    <= 16'h0;
      cycle_q  <= 32'h0;
      cmp_q    <= 32'hFFFF_FFFF;
      irq_pend <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (mmio_we) begin
        case (bus.addr[15:0])
          OFS_LED: led_q   <= bus.wdata[15:0];
          OFS_CYC: cycle_q <= bus.wdata;
          OFS_CMP: cmp_q   <= bus.wdata;
          default: ;
        endcase
      end
      // New events take priority over a same-edge write-1-to-clear.
      if (cycle_q == cmp_q) begin
        irq_pend <= 1'b1;
      end else if (stat_we && bus.wdata[0]) begin
        irq_pend <= 1'b0;
      end
      // Only stores flag err: with no read strobe, a misaligned load address is indistinguishable from a non-memory ALU result.
      if (bus.mem_w && !mmio_sel && misalign) begin
        err_q <= 1'b1;
      end else if (stat_we && bus.wdata[1]) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.rdata = mmio_sel ? mmio_rdata : (misalign ? 32'h0 : ram_rdata);
  assign led       = led_q;
  assign irq       = irq_pend;
`else
  // Without the page every access lands in RAM; lane selection already ignores sub-alignment bits.
  assign ram_we    = bus.mem_w;
  assign bus.rdata = ram_rdata;
  assign led       = 16'h0;
  assign irq       = 1'b0;
`endif

endmodule
